// File: rtl/memreg_bank_arbiter.sv
// memreg_bank_arbiter: two-requester arbiter/sequencer for a bank of memory register bits.
// MEMREG_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to requester 0.
module memreg_bank_arbiter #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic             din0,
  input  logic             din1,
  output logic             ack0,
  output logic             ack1,
  output logic             rdata,
  output logic             busy,
  output logic [DEPTH-1:0] mem_enter,
  output logic             mem_set,
  output logic             mem_d,
  input  logic [DEPTH-1:0] mem_q
);
  typedef enum logic [1:0] {INIT, IDLE, ACCESS, DONE} state_t;
  state_t r_state, w_next;
  logic r_wr, r_din, r_gnt, r_rdata;
  logic [AW-1:0] r_addr;
  logic [DEPTH-1:0] w_sel;
  logic w_win, w_go;
  assign w_go = r_state == IDLE && (req0 || req1);
`ifdef MEMREG_ARB_RR_EN
  logic r_ptr;
  assign w_win = (req0 && req1) ? r_ptr : !req0;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ptr <= 1'b0;
    else if (w_go) r_ptr <= !w_win;
`else
  assign w_win = !req0;
`endif
  // out-of-range addresses match no cell, so they neither write nor read
  for (genvar i = 0; i < DEPTH; i++) begin : g_sel
    assign w_sel[i] = r_addr == AW'(i);
  end
  always_comb
    w_next = r_state == INIT ? IDLE :
             r_state == IDLE ? (w_go ? ACCESS : IDLE) :
             r_state == ACCESS ? DONE : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= INIT;
      r_wr <= 1'b0;
      r_din <= 1'b0;
      r_gnt <= 1'b0;
      r_addr <= '0;
      r_rdata <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_gnt <= w_win;
        r_wr <= w_win ? wr1 : wr0;
        r_din <= w_win ? din1 : din0;
        r_addr <= w_win ? addr1 : addr0;
      end
      if (r_state == ACCESS && !r_wr) r_rdata <= |(w_sel & mem_q);
    end
  assign mem_enter = (r_state == ACCESS && r_wr) ? w_sel : '0;
  assign mem_d = r_state == ACCESS && r_wr && r_din;
  assign mem_set = r_state == INIT;
  assign busy = r_state != IDLE;
  assign ack0 = r_state == DONE && !r_gnt;
  assign ack1 = r_state == DONE && r_gnt;
  assign rdata = r_rdata;
endmodule

// File: tb/tb_memreg_bank_arbiter.sv
// tb_memreg_bank_arbiter: random and directed checks of memreg_bank_arbiter against a transaction-level model.
module tb_memreg_bank_arbiter;
  localparam int DEPTH = 8;
  localparam int AW = 4;
  logic clk = 0, reset = 1;
  logic req0 = 0, req1 = 0, wr0 = 0, wr1 = 0, din0 = 0, din1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic ack0, ack1, rdata, busy, mem_set, mem_d;
  logic [DEPTH-1:0] mem_enter, mem_q;
  logic [DEPTH-1:0] cells = 8'h5A;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  memreg_bank_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy), .mem_enter(mem_enter), .mem_set(mem_set), .mem_d(mem_d),
    .mem_q(mem_q));
  // the cell bank itself: preset dominates, otherwise enabled cells load mem_d
  always @(posedge clk)
    cells <= mem_set ? '1 : ((cells & ~mem_enter) | ({DEPTH{mem_d}} & mem_enter));
  assign mem_q = cells;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // transaction model: cycles left in the current transaction plus a reference memory
  int m_left = 0;
  logic m_init = 1, m_ptr = 0, t_who = 0, t_wr = 0, t_din = 0, m_rdata = 0;
  logic [AW-1:0] t_addr = '0;
  logic [15:0] ref_mem = 16'h005A;
  function automatic logic pick();
`ifdef MEMREG_ARB_RR_EN
    return (req0 && req1) ? m_ptr : !req0;
`else
    return !req0;
`endif
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_init <= 1;
      m_left <= 0;
      m_ptr <= 0;
      m_rdata <= 0;
      if (clk) ref_mem <= 16'h00FF;
    end else if (m_init) begin
      m_init <= 0;
      ref_mem <= 16'h00FF;
    end else if (m_left == 0) begin
      if (req0 || req1) begin
        t_who <= pick();
        t_wr <= pick() ? wr1 : wr0;
        t_din <= pick() ? din1 : din0;
        t_addr <= pick() ? addr1 : addr0;
        m_ptr <= !pick();
        m_left <= 2;
      end
    end else if (m_left == 2) begin
      if (t_wr && t_addr < DEPTH) ref_mem[t_addr] <= t_din;
      if (!t_wr) m_rdata <= (t_addr < DEPTH) ? ref_mem[t_addr] : 1'b0;
      m_left <= 1;
    end else m_left <= 0;
  end
  logic [15:0] exp_oh;
  assign exp_oh = 16'(1) << t_addr;
  always @(negedge clk) begin
    chk("busy", busy, m_init || m_left != 0);
    chk("mem_set", mem_set, m_init);
    chk("ack0", ack0, m_left == 1 && !t_who);
    chk("ack1", ack1, m_left == 1 && t_who);
    chk("mem_enter", mem_enter, (m_left == 2 && t_wr && t_addr < DEPTH) ? exp_oh[DEPTH-1:0] : '0);
    chk("mem_d", mem_d, m_left == 2 && t_wr && t_din);
    chk("rdata", rdata, m_rdata);
    chk("cells", cells, ref_mem[DEPTH-1:0]);
  end
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask
  task automatic go(input logic who, input logic wr, input logic [AW-1:0] a, input logic d);
    @(negedge clk);
    if (who) begin req1 = 1; wr1 = wr; addr1 = a; din1 = d; end
    else begin req0 = 1; wr0 = wr; addr0 = a; din0 = d; end
    @(posedge clk); #1;
  endtask
  int a0, a1;
  logic [DEPTH-1:0] saved;
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    #1 chk("lit_set_after_release", mem_set, 1);
    chk("lit_busy_after_release", busy, 1);
    @(posedge clk); #1;
    chk("lit_set_one_edge", mem_set, 0);
    chk("lit_busy_idle", busy, 0);
    chk("lit_preset", cells, 8'hFF);
    go(0, 1, 5, 0);
    chk("lit_enter5", mem_enter, 8'b0010_0000);
    req0 = 0; addr0 = 2; din0 = 1;
    @(posedge clk); #1;
    chk("lit_ack0", ack0, 1);
    chk("lit_cells_w5", cells, 8'hDF);
    @(posedge clk); #1;
    go(1, 0, 5, 0);
    req1 = 0;
    @(posedge clk); #1;
    chk("lit_ack1", ack1, 1);
    chk("lit_rdata5", rdata, 0);
    @(posedge clk); #1;
    go(0, 1, 9, 1);
    chk("lit_enter_oor", mem_enter, 0);
    req0 = 0;
    @(posedge clk); #1;
    chk("lit_ack_oor_w", ack0, 1);
    @(posedge clk); #1;
    go(0, 0, 0, 0);
    req0 = 0;
    @(posedge clk); #1;
    chk("lit_rdata0", rdata, 1);
    @(posedge clk); #1;
    go(0, 0, 9, 0);
    req0 = 0;
    @(posedge clk); #1;
    chk("lit_ack_oor_r", ack0, 1);
    chk("lit_rdata_oor", rdata, 0);
    wait_idle();
    req0 = 1; req1 = 1; wr0 = 0; wr1 = 0;
    a0 = 0; a1 = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      a0 += int'(ack0);
      a1 += int'(ack1);
    end
`ifdef MEMREG_ARB_RR_EN
    chk("lit_rr_ack0", a0, 4);
    chk("lit_rr_ack1", a1, 4);
`else
    chk("lit_fp_ack0", a0, 8);
    chk("lit_fp_ack1", a1, 0);
`endif
    req0 = 0; req1 = 0;
    wait_idle();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      req0 = $urandom_range(0, 1);
      req1 = $urandom_range(0, 1);
      wr0 = $urandom_range(0, 1);
      wr1 = $urandom_range(0, 1);
      addr0 = AW'($urandom_range(0, 15));
      addr1 = AW'($urandom_range(0, 15));
      din0 = $urandom_range(0, 1);
      din1 = $urandom_range(0, 1);
    end
    @(negedge clk);
    req0 = 0; req1 = 0;
    wait_idle();
    saved = cells;
    go(0, 1, 3, !saved[3]);
    req0 = 0;
    @(negedge clk);
    #2 reset = 1;
    #1 chk("lit_rst_enter", mem_enter, 0);
    chk("lit_rst_ack", ack0, 0);
    chk("lit_rst_set", mem_set, 1);
    chk("lit_rst_cells", cells, saved);
    @(negedge clk);
    chk("lit_rst_preset", cells, 8'hFF);
    reset = 0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
